d_ff_pipeline: RTL and testbench
================================

Name: d_ff_pipeline

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tracking.
- A clock-enable input replaces clock gating; clk always runs.
- Adds a flush input, a configurable reset value and an optional occupancy counter.
- Used as the standard retiming/alignment element between datapath blocks.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages (>=1); latency in enabled cycles
- RESET_VALUE, {WIDTH{1'b0}}, data value loaded into every stage on reset

Ports:
- clk  input  1  system clock, rising edge, free-running (never gated)
- sync_reset  input  1  synchronous reset, active-high
- i_enable  input  1  clock enable; stages advance only when 1
- i_flush  input  1  clears all valid bits; data regs untouched
- i_valid  input  1  qualifies i_value
- i_value  input  WIDTH  data into stage 0
- o_valid  output  1  valid bit of stage DEPTH-1
- o_value  output  WIDTH  data of stage DEPTH-1
- o_occupancy  output  $clog2(DEPTH+1)  count of valid stages (only with D_FF_PIPELINE_OCCUPANCY_EN)

Behaviour:
- Reset: the only clock is clk; reset is synchronous and active-high on sync_reset. No asynchronous reset path exists.
- Priority per rising edge: sync_reset > i_flush > i_enable > hold.
- sync_reset=1: every stage data <= RESET_VALUE; every valid <= 0; o_occupancy <= 0.
  - Reset mid-stream discards all in-flight data.
  - First edge after release behaves as a normal edge.
- i_flush=1 (no reset): all valid bits <= 0, including stage 0, so i_valid that cycle is dropped. Data regs hold. o_occupancy <= 0. This applies regardless of i_enable.
- i_enable=1 (no reset, no flush):
  - stage0 <= {i_valid, i_value}; stage k <= stage k-1 for k=1..DEPTH-1.
  - Data shifts even when i_valid=0 (no bubble squeezing).
- i_enable=0: all stages hold; i_valid/i_value are ignored.
- Latency: a sample accepted at enabled edge n appears on o_value/o_valid after enabled edge n+DEPTH-1, i.e. DEPTH enabled edges from input to output register. Disabled cycles stretch latency and do not lose data.
- Outputs are direct register outputs; no combinational path from inputs to outputs.
- o_value is not masked when o_valid=0; it shows stale stage data (RESET_VALUE after reset).
- DEPTH=1: a single register with enable, flush and reset; the same rules apply.
- Width rules: no arithmetic on data. Occupancy is computed as old + i_valid - o_valid (pre-edge values), saturating is never needed since range is 0..DEPTH.

Optional Feature:
- Macro: D_FF_PIPELINE_OCCUPANCY_EN.
- Defined: o_occupancy port and counter exist.
  - Counter updates only on enabled edges (not reset, not flushed): occ <= occ + i_valid - o_valid.
  - Reset or flush forces occ to 0. Holds when i_enable=0.
  - Invariant: occ equals the popcount of the valid bits.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package d_ff_pkg:
  - default WIDTH/DEPTH localparams
  - function occ_width(depth) returning $clog2(depth+1)
  - typedef for the stage record {valid, data}
- Sub-module d_ff_stage: one register slice (data+valid) with sync_reset, flush, enable and RESET_VALUE parameter.
- d_ff_pipeline instantiates DEPTH d_ff_stage instances in a generate loop, plus the optional counter.

Test Plan (WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5):
- Reset: hold sync_reset=1 for 2 edges -> o_value=8'hA5, o_valid=0, o_occupancy=0. Release; outputs are unchanged until 4 enabled edges have passed.
- Latency: i_enable=1, i_valid=1, drive 8'h01,02,03,04,05 on consecutive edges -> o_value=8'h01 with o_valid=1 after the 4th edge, then 02..05 on the following edges; o_occupancy reaches 4.
- Enable stall: send 8'h10 then drop i_enable for 3 cycles -> outputs frozen for 3 cycles; 8'h10 emerges after 4 enabled edges total; no sample lost or duplicated.
- Flush with input: pipe full of 8'h20..23, assert i_flush with i_valid=1, i_value=8'h24 -> next edge o_valid=0 and all valids=0, o_occupancy=0, o_value still 8'h20 (data held); 8'h24 never appears valid.
- Priority: assert sync_reset, i_flush and i_enable together -> reset wins: o_value=8'hA5, o_valid=0.
- Bubbles: i_valid pattern 1,0,1,0 with data 8'h31,32,33,34 -> o_valid pattern 1,0,1,0 after 4 edges with data 31,32,33,34; o_occupancy steady at 2.

Source files
------------

// File: rtl/d_ff_pkg.sv
// Shared defaults, occupancy width helper and stage record for the d_ff_pipeline delay line.
package d_ff_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32'd8;
    localparam int unsigned DEFAULT_DEPTH = 32'd4;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One register slice of the delay line: data plus valid, with synchronous reset,
// flush (valid only) and clock enable.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             flush,
    input  logic             enable,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_value,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_value
);

    logic             valid_r;
    logic [WIDTH-1:0] value_r;

    // Slice register: reset > flush (data kept) > enable > hold.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            valid_r <= 1'b0;
            value_r <= RESET_VALUE;
        end else if (flush) begin
            valid_r <= 1'b0;
            value_r <= value_r;
        end else if (enable) begin
            valid_r <= d_valid;
            value_r <= d_value;
        end else begin
            valid_r <= valid_r;
            value_r <= value_r;
        end
    end

    assign q_valid = valid_r;
    assign q_value = value_r;

endmodule

// File: rtl/d_ff_pipeline.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tracking.
// Optional occupancy counter enabled by D_FF_PIPELINE_OCCUPANCY_EN.
module d_ff_pipeline
    import d_ff_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        sync_reset,
    input  logic                        i_enable,
    input  logic                        i_flush,
    input  logic                        i_valid,
    input  logic [WIDTH-1:0]            i_value,
`ifdef D_FF_PIPELINE_OCCUPANCY_EN
    output logic [occ_width(DEPTH)-1:0] o_occupancy,
`endif
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_value
);

    logic [DEPTH-1:0] valid_s;
    logic [WIDTH-1:0] value_s [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 32'd0) begin : g_head
            d_ff_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
                .clk        (clk),
                .sync_reset (sync_reset),
                .flush      (i_flush),
                .enable     (i_enable),
                .d_valid    (i_valid),
                .d_value    (i_value),
                .q_valid    (valid_s[k]),
                .q_value    (value_s[k])
            );
        end else begin : g_tail
            d_ff_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
                .clk        (clk),
                .sync_reset (sync_reset),
                .flush      (i_flush),
                .enable     (i_enable),
                .d_valid    (valid_s[k - 32'd1]),
                .d_value    (value_s[k - 32'd1]),
                .q_valid    (valid_s[k]),
                .q_value    (value_s[k])
            );
        end
    end

    assign o_valid = valid_s[DEPTH - 32'd1];
    assign o_value = value_s[DEPTH - 32'd1];

`ifdef D_FF_PIPELINE_OCCUPANCY_EN
    localparam int unsigned OW = occ_width(DEPTH);

    logic [OW-1:0] occ_r;
    logic [OW-1:0] occ_next_s;

    // Next count from the pre-edge input valid and output valid.
    always_comb begin
        occ_next_s = occ_r;
        case ({i_valid, valid_s[DEPTH - 32'd1]})
            2'b10:   occ_next_s = occ_r + OW'(1'b1);
            2'b01:   occ_next_s = occ_r - OW'(1'b1);
            default: occ_next_s = occ_r;
        endcase
    end

    // Occupancy register: cleared by reset or flush, advances only on enabled edges.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            occ_r <= OW'(1'b0);
        end else if (i_flush) begin
            occ_r <= OW'(1'b0);
        end else if (i_enable) begin
            occ_r <= occ_next_s;
        end else begin
            occ_r <= occ_r;
        end
    end

    assign o_occupancy = occ_r;
`endif

endmodule

// File: tb/tb_d_ff_pipeline.sv
// Scoreboard bench for d_ff_pipeline (WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5).
module tb_d_ff_pipeline;

    localparam int unsigned W  = 32'd8;
    localparam int unsigned D  = 32'd4;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_flush = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_value = 8'h00;
    logic       o_valid;
    logic [7:0] o_value;
`ifdef D_FF_PIPELINE_OCCUPANCY_EN
    logic [2:0] o_occupancy;
`endif

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;
    bit adv      = 1'b0;

    typedef struct {
        logic [7:0] val;
        int         due;
    } exp_t;
    exp_t sb[$];

    d_ff_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .i_enable    (i_enable),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .i_value     (i_value),
`ifdef D_FF_PIPELINE_OCCUPANCY_EN
        .o_occupancy (o_occupancy),
`endif
        .o_valid     (o_valid),
        .o_value     (o_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_occ(input string name, input int exp);
`ifdef D_FF_PIPELINE_OCCUPANCY_EN
        chk(name, 32'(o_occupancy), exp);
`endif
    endtask

    // Drive one edge; record expected outputs for accepted samples.
    task automatic step(input logic rst, input logic fl, input logic en,
                        input logic v, input logic [7:0] d);
        sync_reset = rst;
        i_flush    = fl;
        i_enable   = en;
        i_valid    = v;
        i_value    = d;
        @(posedge clk);
        if (rst || fl) begin
            sb.delete();
            adv = 1'b0;
        end else if (en) begin
            en_cnt++;
            adv = 1'b1;
            if (v) sb.push_back('{d, en_cnt + int'(D) - 1});
        end else begin
            adv = 1'b0;
        end
        @(negedge clk);
    endtask

    // Monitor: after each advancing edge, match any valid output to the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (adv) begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_spurious: got valid %0h expected no output", o_value);
                end else begin
                    e = sb.pop_front();
                    chk("out_value", o_value, e.val);
                    chk("out_latency", en_cnt, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= en_cnt) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL out_missing: got o_valid=0 expected %0h", e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two edges.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_value", o_value, RV);
        chk("reset_valid", o_valid, 1'b0);
        chk_occ("reset_occ", 0);

        // Latency: 01..05 back to back.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 8'(i + 1));
            if (i < 3) begin
                chk("release_value", o_value, RV);
                chk("release_valid", o_valid, 1'b0);
            end else begin
                chk_occ("occ_full", 4);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk_occ("occ_drain", 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("stale_value", o_value, 8'h00);
        chk("stale_valid", o_valid, 1'b0);
        chk_occ("occ_empty", 0);

        // Enable stall: input during stall must be ignored.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
            chk("stall_valid", o_valid, 1'b0);
            chk("stall_value", o_value, 8'h00);
            chk_occ("stall_occ", 1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Flush with valid input; data regs hold.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
        chk_occ("occ_prefill", 4);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h24);
        chk("flush_valid", o_valid, 1'b0);
        chk("flush_value", o_value, 8'h20);
        chk_occ("flush_occ", 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("flush_shift_value", o_value, 8'h21);
        chk("flush_shift_valid", o_valid, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Flush while disabled still clears valids.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h41);
        chk_occ("flush_dis_occ", 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Reset beats flush and enable.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h50);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h51);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        chk("prio_value", o_value, RV);
        chk("prio_valid", o_valid, 1'b0);
        chk_occ("prio_occ", 0);

        // Bubbles: alternating valid, no squeezing.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'((i % 2) == 0), 8'(8'h31 + i));
            if (i >= 3) chk_occ("bubble_occ", 2);
            if (i == 4) begin
                chk("bubble_value", o_value, 8'h32);
                chk("bubble_valid", o_valid, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
